mul_seq: RTL and testbench

Sequential shift-and-add multiplier controller built around a single shared `adder_n` instance of width BITS. It sequences that adder for sign correction, partial-product accumulation and result negation, producing a full 2×BITS product. It sits beside the ALU in the execute stage and serves MULT/MULTU-class instructions through a start/busy/done handshake.

---
 rtl/mul_seq.sv | 182 ++++++++++++++++++
 tb/tb_mul_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiplier producing a 2*BITS product.
// A single shared adder_n performs sign correction, accumulation and negation.

module adder_n #(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            cin,
   output logic [BITS-1:0] sum,
   output logic            cout
);

   // Full-width add with carry-in and carry-out
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};
   end

endmodule

module mul_seq #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_signed,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] prod_hi,
   output logic [BITS-1:0] prod_lo
);

   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS_A,
      S_ABS_B,
      S_RUN,
      S_NEG_LO,
      S_NEG_HI,
      S_DONE
   } state_t;

   state_t          state;
   logic [BITS-1:0] mcand;
   logic [BITS-1:0] hi;
   logic [BITS-1:0] lo;
   logic [CW-1:0]   count;
   logic            neg;
   logic            sgn;
   logic            c_save;

   logic [BITS-1:0] add_a;
   logic [BITS-1:0] add_b;
   logic            add_cin;
   logic [BITS-1:0] add_sum;
   logic            add_cout;

   adder_n #(.BITS(BITS)) u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Route the shared adder inputs according to the current state
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state)
         S_ABS_A: begin
            add_a   = ~mcand;
            add_cin = 1'b1;
         end
         S_ABS_B: begin
            add_a   = ~lo;
            add_cin = 1'b1;
         end
         S_RUN: begin
            add_a = hi;
            add_b = lo[0] ? mcand : '0;
         end
         S_NEG_LO: begin
            add_a   = ~lo;
            add_cin = 1'b1;
         end
         S_NEG_HI: begin
            add_a   = ~hi;
            add_cin = c_save;
         end
         default: ;
      endcase
   end

   // Controller and datapath registers; busy/done are registered alongside
   // the state so they always reflect the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         neg    <= 1'b0;
         sgn    <= 1'b0;
         c_save <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mcand <= a;
                  lo    <= b;
                  hi    <= '0;
                  count <= '0;
                  sgn   <= is_signed;
                  neg   <= is_signed & (a[BITS-1] ^ b[BITS-1]);
                  state <= is_signed ? S_ABS_A : S_RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_ABS_A: begin
               if (mcand[BITS-1]) mcand <= add_sum;
               state <= S_ABS_B;
               busy  <= 1'b1;
            end
            S_ABS_B: begin
               if (lo[BITS-1]) lo <= add_sum;
               state <= S_RUN;
               busy  <= 1'b1;
            end
            S_RUN: begin
               {hi, lo} <= {add_cout, add_sum, lo[BITS-1:1]};
               count    <= count + CW'(1);
               if (count == LAST) begin
                  if (sgn) begin
                     state <= S_NEG_LO;
                     busy  <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  busy <= 1'b1;
               end
            end
            S_NEG_LO: begin
               if (neg) begin
                  lo     <= add_sum;
                  c_save <= add_cout;
               end else begin
                  c_save <= 1'b0;
               end
               state <= S_NEG_HI;
               busy  <= 1'b1;
            end
            S_NEG_HI: begin
               if (neg) hi <= add_sum;
               state <= S_DONE;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign prod_hi = hi;
   assign prod_lo = lo;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq with an arithmetic reference model.

module tb_mul_seq;

   localparam int BITS = 32;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            is_signed;
   logic [BITS-1:0] a;
   logic [BITS-1:0] b;
   logic            busy;
   logic            done;
   logic [BITS-1:0] prod_hi;
   logic [BITS-1:0] prod_lo;

   mul_seq #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .prod_hi   (prod_hi),
      .prod_lo   (prod_lo)
   );

   typedef struct {
      logic [2*BITS-1:0] p;
      int unsigned       acc;
      int unsigned       lat;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2*BITS-1:0] model(input logic [BITS-1:0] x,
                                               input logic [BITS-1:0] y,
                                               input logic s);
      longint sx;
      longint sy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      return {32'b0, x} * {32'b0, y};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pop an expectation whenever done is presented
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_done) check("done_one_cycle", 64'(done & prev_done), 64'd0);
         if (done) begin
            exp_t e;
            check("busy_low_at_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done with empty scoreboard");
            end else begin
               e = exp_q.pop_front();
               check("product", {prod_hi, prod_lo}, e.p);
               check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   task automatic issue(input logic [BITS-1:0] ia, input logic [BITS-1:0] ib, input logic s);
      int unsigned n = 0;
      exp_t e;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: busy stuck %0d cycles", n);
      end
      start = 1'b1;
      a = ia;
      b = ib;
      is_signed = s;
      @(posedge clk);
      #1;
      e.p = model(ia, ib, s);
      e.acc = cyc;
      e.lat = s ? BITS + 4 : BITS;
      exp_q.push_back(e);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      is_signed = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_prod", {prod_hi, prod_lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operands from the plan
      issue(32'd3, 32'd5, 1'b0);
      drain();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue(32'hFFFF_FFFD, 32'd5, 1'b1);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 1'b1);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      issue(32'd0, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Start while busy must be ignored
      issue(32'd1234, 32'd5678, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      a = 32'hDEAD_BEEF;
      b = 32'h1234_5678;
      is_signed = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Random back-to-back mix
      for (int i = 0; i < 24; i++) begin
         issue($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      drain();

      // Asynchronous reset in the middle of RUN
      issue(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
      repeat (15) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_done", 64'(done), 64'd0);
      check("midreset_prod", {prod_hi, prod_lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd7, 32'd6, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
